// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin arbiter and access sequencer in front of the
// single-port data_memory word array. It serves two requesters over a
// valid/ready handshake, turns partial stores into read-modify-write sequences,
// and rejects out-of-range word addresses before they reach the memory.
module data_memory_arbiter #(
  parameter int ADDRESS_WIDTH     = 30,
  parameter int DATA_WIDTH        = 32,
  parameter int MEMORY_WORDS_LOG2 = 10
) (
  input  logic                      clock,
  input  logic                      reset,

  input  logic                      req_0_valid,
  input  logic                      req_0_write,
  input  logic [ADDRESS_WIDTH-1:0]  req_0_address,
  input  logic [DATA_WIDTH/8-1:0]   req_0_byte_enable,
  input  logic [DATA_WIDTH-1:0]     req_0_write_data,
  output logic                      req_0_ready,
  output logic [DATA_WIDTH-1:0]     req_0_read_data,
  output logic                      req_0_error,

  input  logic                      req_1_valid,
  input  logic                      req_1_write,
  input  logic [ADDRESS_WIDTH-1:0]  req_1_address,
  input  logic [DATA_WIDTH/8-1:0]   req_1_byte_enable,
  input  logic [DATA_WIDTH-1:0]     req_1_write_data,
  output logic                      req_1_ready,
  output logic [DATA_WIDTH-1:0]     req_1_read_data,
  output logic                      req_1_error,

  output logic [ADDRESS_WIDTH-1:0]  mem_address,
  output logic                      mem_write_enable,
  output logic [DATA_WIDTH-1:0]     mem_write_input,
  input  logic [DATA_WIDTH-1:0]     mem_read_result
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE_WRITE,
    RESPOND
  } state_t;

  state_t                    state;
  logic                      priority_port;
  logic                      grant_port;
  logic                      lat_write;
  logic [ADDRESS_WIDTH-1:0]  lat_address;
  logic [BE_WIDTH-1:0]       lat_byte_enable;
  logic [DATA_WIDTH-1:0]     lat_write_data;
  logic [DATA_WIDTH-1:0]     merge_word;

  logic                      out_of_range;
  logic                      full_store;
  logic                      empty_store;
  logic                      partial_store;
  logic [DATA_WIDTH-1:0]     merged_word;
  logic                      next_grant;
  logic                      finish_access;
  logic [DATA_WIDTH-1:0]     response_data;
  logic                      response_error;

  // Decode the latched request, build the merged word and pick the next grant.
  always_comb begin
    out_of_range  = (lat_address >> MEMORY_WORDS_LOG2) != '0;
    full_store    = lat_write && (&lat_byte_enable);
    empty_store   = lat_write && (lat_byte_enable == '0);
    partial_store = lat_write && !out_of_range && !full_store && !empty_store;

    merged_word = mem_read_result;
    for (int k = 0; k < BE_WIDTH; k++) begin
      if (lat_byte_enable[k]) begin
        merged_word[8*k +: 8] = lat_write_data[8*k +: 8];
      end
    end

    if (req_0_valid && req_1_valid) begin
      next_grant = priority_port;
    end else if (req_1_valid) begin
      next_grant = 1'b1;
    end else begin
      next_grant = 1'b0;
    end

    finish_access = ((state == ACCESS) && !partial_store) || (state == MERGE_WRITE);

    if (out_of_range) begin
      response_data  = '0;
      response_error = 1'b1;
    end else if (lat_write) begin
      response_data  = '0;
      response_error = 1'b0;
    end else begin
      response_data  = mem_read_result;
      response_error = 1'b0;
    end
  end

  // Drive the memory port; writes are gated off whenever reset is asserted.
  always_comb begin
    mem_address      = lat_address;
    mem_write_enable = 1'b0;
    mem_write_input  = '0;
    if (state == ACCESS && full_store && !out_of_range) begin
      mem_write_enable = reset;
      mem_write_input  = lat_write_data;
    end else if (state == MERGE_WRITE) begin
      mem_write_enable = reset;
      mem_write_input  = merge_word;
    end
  end

  // Sequencer FSM with the latched request and registered response outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= IDLE;
      priority_port   <= 1'b0;
      grant_port      <= 1'b0;
      lat_write       <= 1'b0;
      lat_address     <= '0;
      lat_byte_enable <= '0;
      lat_write_data  <= '0;
      merge_word      <= '0;
      req_0_ready     <= 1'b0;
      req_0_read_data <= '0;
      req_0_error     <= 1'b0;
      req_1_ready     <= 1'b0;
      req_1_read_data <= '0;
      req_1_error     <= 1'b0;
    end else begin
      if (finish_access) begin
        if (grant_port) begin
          req_1_ready     <= 1'b1;
          req_1_read_data <= response_data;
          req_1_error     <= response_error;
        end else begin
          req_0_ready     <= 1'b1;
          req_0_read_data <= response_data;
          req_0_error     <= response_error;
        end
      end

      case (state)
        IDLE: begin
          if (req_0_valid || req_1_valid) begin
            grant_port <= next_grant;
            if (next_grant) begin
              lat_write       <= req_1_write;
              lat_address     <= req_1_address;
              lat_byte_enable <= req_1_byte_enable;
              lat_write_data  <= req_1_write_data;
            end else begin
              lat_write       <= req_0_write;
              lat_address     <= req_0_address;
              lat_byte_enable <= req_0_byte_enable;
              lat_write_data  <= req_0_write_data;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (partial_store) begin
            merge_word <= merged_word;
            state      <= MERGE_WRITE;
          end else begin
            state <= RESPOND;
          end
        end
        MERGE_WRITE: begin
          state <= RESPOND;
        end
        RESPOND: begin
          req_0_ready   <= 1'b0;
          req_0_error   <= 1'b0;
          req_1_ready   <= 1'b0;
          req_1_error   <= 1'b0;
          priority_port <= ~priority_port;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: table-driven bench for data_memory_arbiter with a
// behavioural word memory, plus hand-written arbitration and reset sequences.
module tb_data_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        req_0_valid = 1'b0;
  logic        req_0_write = 1'b0;
  logic [29:0] req_0_address = '0;
  logic [3:0]  req_0_byte_enable = '0;
  logic [31:0] req_0_write_data = '0;
  logic        req_0_ready;
  logic [31:0] req_0_read_data;
  logic        req_0_error;

  logic        req_1_valid = 1'b0;
  logic        req_1_write = 1'b0;
  logic [29:0] req_1_address = '0;
  logic [3:0]  req_1_byte_enable = '0;
  logic [31:0] req_1_write_data = '0;
  logic        req_1_ready;
  logic [31:0] req_1_read_data;
  logic        req_1_error;

  logic [29:0] mem_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_input;
  logic [31:0] mem_read_result;

  logic [31:0] memory [1024];
  int          we_count = 0;
  int          checks = 0;
  int          failures = 0;

  data_memory_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .req_0_valid       (req_0_valid),
    .req_0_write       (req_0_write),
    .req_0_address     (req_0_address),
    .req_0_byte_enable (req_0_byte_enable),
    .req_0_write_data  (req_0_write_data),
    .req_0_ready       (req_0_ready),
    .req_0_read_data   (req_0_read_data),
    .req_0_error       (req_0_error),
    .req_1_valid       (req_1_valid),
    .req_1_write       (req_1_write),
    .req_1_address     (req_1_address),
    .req_1_byte_enable (req_1_byte_enable),
    .req_1_write_data  (req_1_write_data),
    .req_1_ready       (req_1_ready),
    .req_1_read_data   (req_1_read_data),
    .req_1_error       (req_1_error),
    .mem_address       (mem_address),
    .mem_write_enable  (mem_write_enable),
    .mem_write_input   (mem_write_input),
    .mem_read_result   (mem_read_result)
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  // Behavioural data_memory: combinational read, write on the rising edge.
  assign mem_read_result = memory[mem_address[9:0]];

  always @(posedge clock) begin
    if (mem_write_enable === 1'b1) begin
      memory[mem_address[9:0]] <= mem_write_input;
      we_count <= we_count + 1;
    end
  end

  typedef struct {
    string       name;
    bit          port;
    bit          write;
    logic [29:0] address;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
    logic [31:0] exp_data;
    bit          exp_error;
    int          exp_latency;
    int          exp_writes;
  } vector_t;

  vector_t vectors [$];

  task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req_0_valid = 1'b0;
    req_1_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_value("reset ready0", {31'd0, req_0_ready}, 32'd0);
    check_value("reset ready1", {31'd0, req_1_ready}, 32'd0);
    check_value("reset error0", {31'd0, req_0_error}, 32'd0);
    check_value("reset error1", {31'd0, req_1_error}, 32'd0);
    check_value("reset rdata0", req_0_read_data, 32'd0);
    check_value("reset rdata1", req_1_read_data, 32'd0);
    check_value("reset mem_address", {2'b00, mem_address}, 32'd0);
    check_value("reset mem_we", {31'd0, mem_write_enable}, 32'd0);
    check_value("reset mem_wdata", mem_write_input, 32'd0);
    reset = 1'b1;
  endtask

  task automatic drive_port(input bit port, input bit write, input logic [29:0] address,
                            input logic [3:0] byte_enable, input logic [31:0] write_data);
    if (port) begin
      req_1_write = write; req_1_address = address;
      req_1_byte_enable = byte_enable; req_1_write_data = write_data;
      req_1_valid = 1'b1;
    end else begin
      req_0_write = write; req_0_address = address;
      req_0_byte_enable = byte_enable; req_0_write_data = write_data;
      req_0_valid = 1'b1;
    end
  endtask

  // Runs one single-port transaction from an IDLE cycle and checks its response.
  task automatic apply_stimulus(input vector_t v);
    int  cycle;
    bit  got;
    bit  other_seen;
    int  start_writes;
    logic [31:0] data;
    logic        err;
    start_writes = we_count;
    drive_port(v.port, v.write, v.address, v.byte_enable, v.write_data);
    cycle = 0; got = 0; other_seen = 0;
    while (!got && cycle < 10) begin
      @(posedge clock);
      #1;
      cycle++;
      if ((v.port ? req_0_ready : req_1_ready) === 1'b1) other_seen = 1;
      if ((v.port ? req_1_ready : req_0_ready) === 1'b1) got = 1;
    end
    data = v.port ? req_1_read_data : req_0_read_data;
    err  = v.port ? req_1_error : req_0_error;
    req_0_valid = 1'b0;
    req_1_valid = 1'b0;
    check_output(v, got ? cycle : -1, data, err, other_seen);
    @(posedge clock);
    #1;
    check_value({v.name, " writes"}, we_count - start_writes, v.exp_writes);
    check_value({v.name, " ready drops"}, {30'd0, req_1_ready, req_0_ready}, 32'd0);
  endtask

  task automatic check_output(input vector_t v, input int latency, input logic [31:0] data,
                              input logic err, input bit other_seen);
    check_value({v.name, " latency"}, latency, v.exp_latency);
    check_value({v.name, " data"}, data, v.exp_data);
    check_value({v.name, " error"}, {31'd0, err}, {31'd0, v.exp_error});
    check_value({v.name, " other ready"}, {31'd0, other_seen}, 32'd0);
  endtask

  function automatic vector_t mk(input string name, input bit port, input bit write,
                                 input logic [29:0] address, input logic [3:0] be,
                                 input logic [31:0] wdata, input logic [31:0] exp_data,
                                 input bit exp_error, input int exp_latency, input int exp_writes);
    vector_t v;
    v.name = name; v.port = port; v.write = write; v.address = address;
    v.byte_enable = be; v.write_data = wdata; v.exp_data = exp_data;
    v.exp_error = exp_error; v.exp_latency = exp_latency; v.exp_writes = exp_writes;
    return v;
  endfunction

  initial begin
    int          done_port [4];
    logic [31:0] done_data [4];
    int          done_cycle [4];
    int          done;
    int          cycle;
    bit          both_ready;
    int          start_writes;
    bit          ready_seen;

    for (int i = 0; i < 1024; i++) memory[i] = 32'd0;

    vectors.push_back(mk("load w2",          0, 0, 30'd2,     4'h0, 32'h0,        32'h00000000, 0, 2, 0));
    vectors.push_back(mk("full store w4",    1, 1, 30'd4,     4'hF, 32'hAAAAAAAA, 32'h00000000, 0, 2, 1));
    vectors.push_back(mk("load w4 full",     1, 0, 30'd4,     4'h0, 32'h0,        32'hAAAAAAAA, 0, 2, 0));
    vectors.push_back(mk("partial 0011",     0, 1, 30'd4,     4'h3, 32'h12345678, 32'h00000000, 0, 3, 1));
    vectors.push_back(mk("load w4 merged",   0, 0, 30'd4,     4'h0, 32'h0,        32'hAAAA5678, 0, 2, 0));
    vectors.push_back(mk("oor store 402",    1, 1, 30'h402,   4'hF, 32'hDEADBEEF, 32'h00000000, 1, 2, 0));
    vectors.push_back(mk("load w2 after oor",0, 0, 30'd2,     4'h0, 32'h0,        32'h00000000, 0, 2, 0));
    vectors.push_back(mk("oor load 400",     1, 0, 30'h400,   4'h0, 32'h0,        32'h00000000, 1, 2, 0));
    vectors.push_back(mk("empty store w5",   0, 1, 30'd5,     4'h0, 32'hFFFFFFFF, 32'h00000000, 0, 2, 0));
    vectors.push_back(mk("load w5",          1, 0, 30'd5,     4'h0, 32'h0,        32'h00000000, 0, 2, 0));
    vectors.push_back(mk("partial 1100",     0, 1, 30'd4,     4'hC, 32'hCAFEBABE, 32'h00000000, 0, 3, 1));
    vectors.push_back(mk("load w4 upper",    1, 0, 30'd4,     4'h0, 32'h0,        32'hCAFE5678, 0, 2, 0));
    vectors.push_back(mk("store w1023",      1, 1, 30'd1023,  4'hF, 32'h12345678, 32'h00000000, 0, 2, 1));
    vectors.push_back(mk("load w1023",       0, 0, 30'd1023,  4'h0, 32'h0,        32'h12345678, 0, 2, 0));
    vectors.push_back(mk("restore w4",       0, 1, 30'd4,     4'hF, 32'hAAAAAAAA, 32'h00000000, 0, 2, 1));
    vectors.push_back(mk("oor high bit",     0, 0, 30'h20000000, 4'h0, 32'h0,     32'h00000000, 1, 2, 0));

    @(negedge clock);
    apply_reset();

    foreach (vectors[i]) apply_stimulus(vectors[i]);

    // Both ports held valid after reset: grants alternate starting at port 0.
    apply_reset();
    drive_port(0, 0, 30'd4, 4'h0, 32'h0);
    drive_port(1, 0, 30'd1023, 4'h0, 32'h0);
    done = 0; cycle = 0; both_ready = 0;
    while (done < 4 && cycle < 40) begin
      @(posedge clock);
      #1;
      cycle++;
      if (req_0_ready === 1'b1 && req_1_ready === 1'b1) both_ready = 1;
      if (req_0_ready === 1'b1) begin
        done_port[done] = 0; done_data[done] = req_0_read_data; done_cycle[done] = cycle; done++;
      end else if (req_1_ready === 1'b1) begin
        done_port[done] = 1; done_data[done] = req_1_read_data; done_cycle[done] = cycle; done++;
      end
    end
    req_0_valid = 1'b0;
    req_1_valid = 1'b0;
    check_value("arb completions", done, 4);
    check_value("arb both ready", {31'd0, both_ready}, 32'd0);
    for (int i = 0; i < done; i++) begin
      check_value($sformatf("arb port %0d", i), done_port[i], i % 2);
      check_value($sformatf("arb data %0d", i), done_data[i], (i % 2) ? 32'h12345678 : 32'hAAAAAAAA);
      check_value($sformatf("arb cycle %0d", i), done_cycle[i], 2 + 3 * i);
    end
    @(posedge clock);
    #1;

    // Reset asserted in MERGE_WRITE abandons the partial store.
    apply_reset();
    start_writes = we_count;
    drive_port(0, 1, 30'd4, 4'h1, 32'h000000FF);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_value("merge reset we", {31'd0, mem_write_enable}, 32'd0);
    req_0_valid = 1'b0;
    ready_seen = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (req_0_ready === 1'b1 || req_1_ready === 1'b1) ready_seen = 1;
      @(posedge clock);
      #1;
    end
    check_value("merge reset ready", {31'd0, ready_seen}, 32'd0);
    check_value("merge reset writes", we_count - start_writes, 32'd0);
    apply_stimulus(mk("load w4 after abort", 0, 0, 30'd4, 4'h0, 32'h0, 32'hAAAAAAAA, 0, 2, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
